// File: rtl/maze_pkg.sv
// Shared constants and types for the maze memory arbiter.
package maze_pkg;

    // Cell address width for a 16x16 maze of 1-bit cells.
    localparam int MAZE_ADDR_W = 8;

    // Encoding of the owner output and of the last-owner register.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_SLV  = 2'd1;
    localparam logic [1:0] OWN_HST  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_S = 2'd1,
        GNT_H = 2'd2
    } state_t;

endpackage

// File: rtl/maze_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port that did not own the memory last.
module rr_pick2
    import maze_pkg::*;
(
    input  logic       s_req_i,
    input  logic       h_req_i,
    input  logic [1:0] last_owner_i,
    output logic       pick_s_o,
    output logic       pick_h_o
);

    logic last_hst;

    assign last_hst = (last_owner_i == OWN_HST);

    // Tie-break against the previous owner.
    always_comb begin
        pick_s_o = s_req_i & (~h_req_i | last_hst);
        pick_h_o = h_req_i & (~s_req_i | ~last_hst);
    end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbiter sharing the single-port maze memory between the solver and the
// host. Round-robin grant, lock for atomic sequences, hold limit against
// starvation, and read data routed back to the port that issued the read.
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int ADDR_W   = MAZE_ADDR_W,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_req,
    input  logic              s_lock,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic              s_wdata,
    output logic              s_gnt,
    output logic              s_rvalid,
    output logic              s_rdata,
    input  logic              h_req,
    input  logic              h_lock,
    input  logic              h_wr,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic              h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic              h_rdata,
    output logic [ADDR_W-1:0] m_loc,
    output logic              m_dIn,
    output logic              m_rd,
    output logic              m_wr,
    input  logic              m_dOut,
    output logic [1:0]        owner
);

    localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d, hold_acc;
    logic             s_rv_q, h_rv_q;
    logic             s_acc, h_acc;
    logic             pick_s, pick_h;
    logic             hold_full;

    rr_pick2 u_pick (
        .s_req_i      (s_req),
        .h_req_i      (h_req),
        .last_owner_i (last_q),
        .pick_s_o     (pick_s),
        .pick_h_o     (pick_h)
    );

    // Grants come straight from the state register.
    assign s_gnt = (state_q == GNT_S);
    assign h_gnt = (state_q == GNT_H);
    assign s_acc = s_gnt & s_req;
    assign h_acc = h_gnt & h_req;

    // Count includes the access happening this cycle so the release is
    // decided on the MAX_HOLD-th access; saturates while nobody waits.
    assign hold_acc  = ((s_acc | h_acc) && (hold_q != HOLD_MAX)) ? hold_q + CNT_W'(1) : hold_q;
    assign hold_full = (hold_acc == HOLD_MAX);

    // Read data is only driven during the cycle its tag is valid.
    assign s_rvalid = s_rv_q;
    assign h_rvalid = h_rv_q;
    assign s_rdata  = s_rv_q & m_dOut;
    assign h_rdata  = h_rv_q & m_dOut;

    // State, last owner and hold counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= OWN_HST;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Next grant: release on idle-and-unlocked or on hold limit with the
    // other port waiting; hand over directly when the other port requests.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_acc;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (pick_s) begin
                    state_d = GNT_S;
                end else if (pick_h) begin
                    state_d = GNT_H;
                end
            end
            GNT_S: begin
                if ((!s_req && !s_lock) || (hold_full && h_req)) begin
                    last_d  = OWN_SLV;
                    hold_d  = '0;
                    state_d = h_req ? GNT_H : IDLE;
                end
            end
            GNT_H: begin
                if ((!h_req && !h_lock) || (hold_full && s_req)) begin
                    last_d  = OWN_HST;
                    hold_d  = '0;
                    state_d = s_req ? GNT_S : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Read-return tags remember which port issued the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rv_q <= 1'b0;
            h_rv_q <= 1'b0;
        end else begin
            s_rv_q <= s_acc & ~s_wr;
            h_rv_q <= h_acc & ~h_wr;
        end
    end

    // Memory strobes follow the accepted access of the current owner.
    always_comb begin
        m_loc = '0;
        m_dIn = 1'b0;
        m_rd  = 1'b0;
        m_wr  = 1'b0;
        if (s_acc) begin
            m_loc = s_addr;
            m_dIn = s_wdata;
            m_rd  = ~s_wr;
            m_wr  = s_wr;
        end else if (h_acc) begin
            m_loc = h_addr;
            m_dIn = h_wdata;
            m_rd  = ~h_wr;
            m_wr  = h_wr;
        end
    end

    // Owner code mirrors the grant state.
    always_comb begin
        case (state_q)
            GNT_S:   owner = OWN_SLV;
            GNT_H:   owner = OWN_HST;
            default: owner = OWN_NONE;
        endcase
    end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Testbench for maze_mem_arbiter: directed vector table, hand-written
// reset-during-read sequence, and randomized traffic against a reference model.
module tb_maze_mem_arbiter;

    localparam int AW = 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_req, s_lock, s_wr, s_wdata;
    logic [AW-1:0] s_addr;
    logic          s_gnt, s_rvalid, s_rdata;
    logic          h_req, h_lock, h_wr, h_wdata;
    logic [AW-1:0] h_addr;
    logic          h_gnt, h_rvalid, h_rdata;
    logic [AW-1:0] m_loc;
    logic          m_dIn, m_rd, m_wr, m_dOut;
    logic [1:0]    owner;
    logic          mem_clr;

    always #5 clk = ~clk;

    maze_mem_arbiter #(.ADDR_W(AW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_lock(s_lock), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .h_req(h_req), .h_lock(h_lock), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_loc(m_loc), .m_dIn(m_dIn), .m_rd(m_rd), .m_wr(m_wr), .m_dOut(m_dOut),
        .owner(owner)
    );

    // Single-port maze memory: synchronous write, read data the cycle after m_rd.
    logic mem [0:255];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 1'b0;
        end else if (m_wr) begin
            mem[m_loc] <= m_dIn;
        end
        if (m_rd) m_dOut <= mem[m_loc];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [2:0] sc;   // solver {req, lock, wr}
        logic [7:0] sa;
        logic       sd;
        logic [2:0] hc;   // host {req, lock, wr}
        logic [7:0] ha;
        logic       hd;
        logic [1:0] eg;   // {s_gnt, h_gnt}
        logic [1:0] eo;   // owner
        logic [1:0] em;   // {m_rd, m_wr}
        logic [3:0] er;   // {s_rvalid, s_rdata, h_rvalid, h_rdata}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [2:0] sc, input logic [7:0] sa,
                                input logic sd, input logic [2:0] hc, input logic [7:0] ha,
                                input logic hd, input logic [1:0] eg, input logic [1:0] eo,
                                input logic [1:0] em, input logic [3:0] er);
        vec_t v;
        v.rst = r; v.sc = sc; v.sa = sa; v.sd = sd;
        v.hc = hc; v.ha = ha; v.hd = hd;
        v.eg = eg; v.eo = eo; v.em = em; v.er = er;
        return v;
    endfunction

    function automatic logic [18:0] act();
        return {s_gnt, h_gnt, owner, m_rd, m_wr, m_loc, m_dIn,
                s_rvalid, s_rdata, h_rvalid, h_rdata};
    endfunction

    function automatic logic [18:0] exp_of(input vec_t v);
        logic       acc;
        logic [7:0] loc;
        logic       din;
        acc = |v.em;
        loc = acc ? ((v.eo == 2'd1) ? v.sa : v.ha) : 8'h00;
        din = acc ? ((v.eo == 2'd1) ? v.sd : v.hd) : 1'b0;
        return {v.eg, v.eo, v.em, loc, din, v.er};
    endfunction

    task automatic check(input string name, input int idx, input logic [18:0] got,
                         input logic [18:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b (gnt s,h|own|rd,wr|loc|din|srv,srd,hrv,hrd)",
                     name, idx, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        rst    = v.rst;
        s_req  = v.sc[2]; s_lock = v.sc[1]; s_wr = v.sc[0]; s_addr = v.sa; s_wdata = v.sd;
        h_req  = v.hc[2]; h_lock = v.hc[1]; h_wr = v.hc[0]; h_addr = v.ha; h_wdata = v.hd;
    endtask

    // Reference model state (ports indexed 1 = solver, 2 = host).
    int   m_own, m_last, m_cnt;
    logic m_rv [1:2];
    logic m_rvd[1:2];
    logic ref_mem [0:255];

    task automatic model_reset();
        m_own = 0; m_last = 2; m_cnt = 0;
        m_rv[1] = 1'b0; m_rv[2] = 1'b0; m_rvd[1] = 1'b0; m_rvd[2] = 1'b0;
    endtask

    task automatic random_cycle(input int n);
        logic       rq[1:2], lk[1:2], wr[1:2], wd[1:2];
        logic [7:0] ad[1:2];
        logic       r, acc;
        logic [18:0] want;
        int p, o, c;
        @(negedge clk);
        r = ($urandom_range(0, 99) == 0);
        for (int k = 1; k <= 2; k++) begin
            rq[k] = ($urandom_range(0, 3) != 0);
            lk[k] = ($urandom_range(0, 3) == 0);
            wr[k] = ($urandom_range(0, 2) == 0);
            wd[k] = $urandom_range(0, 1) == 1;
            ad[k] = 8'($urandom_range(0, 15));
        end
        rst = r;
        s_req = rq[1]; s_lock = lk[1]; s_wr = wr[1]; s_addr = ad[1]; s_wdata = wd[1];
        h_req = rq[2]; h_lock = lk[2]; h_wr = wr[2]; h_addr = ad[2]; h_wdata = wd[2];
        #1;
        p = m_own;
        acc = 1'b0;
        if (p != 0) acc = rq[p];
        if (r) begin
            want = '0;
        end else begin
            want = {p == 1, p == 2, 2'(p),
                    acc && !wr[p], acc && wr[p],
                    acc ? ad[p] : 8'h00, acc ? wd[p] : 1'b0,
                    m_rv[1], m_rv[1] & m_rvd[1], m_rv[2], m_rv[2] & m_rvd[2]};
        end
        check("random", n, act(), want);
        if (r) begin
            model_reset();
        end else begin
            m_rv[1] = 1'b0; m_rv[2] = 1'b0;
            if (acc && !wr[p]) begin
                m_rv[p]  = 1'b1;
                m_rvd[p] = ref_mem[ad[p]];
            end
            if (acc && wr[p]) ref_mem[ad[p]] = wd[p];
            if (p == 0) begin
                if (rq[1] && rq[2]) m_own = (m_last == 2) ? 1 : 2;
                else if (rq[1])     m_own = 1;
                else if (rq[2])     m_own = 2;
                m_cnt = 0;
            end else begin
                o = 3 - p;
                c = m_cnt + (acc ? 1 : 0);
                if (c > MH) c = MH;
                if ((!rq[p] && !lk[p]) || (c >= MH && rq[o])) begin
                    m_last = p;
                    m_own  = rq[o] ? o : 0;
                    m_cnt  = 0;
                end else begin
                    m_cnt = c;
                end
            end
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(1'b0, 3'b000, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 2'b00, 2'd0, 2'b00, 4'b0000);
        apply(idle);
        rst = 1'b1;
        mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset", 0, act(), 19'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_clr = 1'b0;

        // host preloads 0x11, solver reads it alone
        tbl.push_back(idle);
        tbl.push_back(mk(1'b0, 3'b000, 8'h00, 1'b0, 3'b101, 8'h11, 1'b1, 2'b00, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 8'h00, 1'b0, 3'b101, 8'h11, 1'b1, 2'b01, 2'd2, 2'b01, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 8'h00, 1'b0, 3'b000, 8'h11, 1'b0, 2'b01, 2'd2, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 2'b00, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 2'b10, 2'd1, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 2'b10, 2'd1, 2'b00, 4'b1100));
        tbl.push_back(idle);
        // tie with last owner = solver -> host; handover without idle cycle
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b100, 8'h11, 1'b0, 2'b00, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b100, 8'h11, 1'b0, 2'b01, 2'd2, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h23, 1'b0, 3'b000, 8'h11, 1'b0, 2'b01, 2'd2, 2'b00, 4'b0011));
        tbl.push_back(mk(1'b0, 3'b100, 8'h23, 1'b0, 3'b000, 8'h00, 1'b0, 2'b10, 2'd1, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 8'h23, 1'b0, 3'b000, 8'h00, 1'b0, 2'b10, 2'd1, 2'b00, 4'b1000));
        // reset, then tie goes to solver
        tbl.push_back(mk(1'b1, 3'b000, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 2'b00, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b00, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b10, 2'd1, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b10, 2'd1, 2'b10, 4'b1100));
        tbl.push_back(mk(1'b0, 3'b000, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b10, 2'd1, 2'b00, 4'b1100));
        tbl.push_back(mk(1'b0, 3'b000, 8'h00, 1'b0, 3'b100, 8'h23, 1'b0, 2'b01, 2'd2, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 8'h00, 1'b0, 3'b000, 8'h23, 1'b0, 2'b01, 2'd2, 2'b00, 4'b0010));
        tbl.push_back(idle);
        // lock: check-then-mark of 0x23 while host waits
        tbl.push_back(mk(1'b0, 3'b110, 8'h23, 1'b0, 3'b100, 8'h11, 1'b0, 2'b00, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b110, 8'h23, 1'b0, 3'b100, 8'h11, 1'b0, 2'b10, 2'd1, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b010, 8'h23, 1'b0, 3'b100, 8'h11, 1'b0, 2'b10, 2'd1, 2'b00, 4'b1000));
        tbl.push_back(mk(1'b0, 3'b010, 8'h23, 1'b0, 3'b100, 8'h11, 1'b0, 2'b10, 2'd1, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b010, 8'h23, 1'b0, 3'b100, 8'h11, 1'b0, 2'b10, 2'd1, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b111, 8'h23, 1'b1, 3'b100, 8'h11, 1'b0, 2'b10, 2'd1, 2'b01, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 8'h23, 1'b0, 3'b100, 8'h23, 1'b0, 2'b10, 2'd1, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 8'h00, 1'b0, 3'b100, 8'h23, 1'b0, 2'b01, 2'd2, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b000, 8'h00, 1'b0, 3'b000, 8'h23, 1'b0, 2'b01, 2'd2, 2'b00, 4'b0011));
        // hold limit: 4 locked solver accesses, then host
        tbl.push_back(mk(1'b0, 3'b110, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b00, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b110, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b10, 2'd1, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b110, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b10, 2'd1, 2'b10, 4'b1100));
        tbl.push_back(mk(1'b0, 3'b110, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b10, 2'd1, 2'b10, 4'b1100));
        tbl.push_back(mk(1'b0, 3'b110, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b10, 2'd1, 2'b10, 4'b1100));
        tbl.push_back(mk(1'b0, 3'b110, 8'h11, 1'b0, 3'b100, 8'h23, 1'b0, 2'b01, 2'd2, 2'b10, 4'b1100));
        tbl.push_back(mk(1'b0, 3'b110, 8'h11, 1'b0, 3'b000, 8'h23, 1'b0, 2'b01, 2'd2, 2'b00, 4'b0011));
        tbl.push_back(mk(1'b0, 3'b000, 8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 2'b10, 2'd1, 2'b00, 4'b0000));
        tbl.push_back(idle);
        // host writes 0xFF, reads it on its last allowed access; read returns after handover
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b101, 8'hFF, 1'b1, 2'b00, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b101, 8'hFF, 1'b1, 2'b01, 2'd2, 2'b01, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b101, 8'hFF, 1'b1, 2'b01, 2'd2, 2'b01, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b101, 8'hFF, 1'b1, 2'b01, 2'd2, 2'b01, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b100, 8'hFF, 1'b0, 2'b01, 2'd2, 2'b10, 4'b0000));
        tbl.push_back(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 2'b10, 2'd1, 2'b10, 4'b0011));
        tbl.push_back(mk(1'b0, 3'b000, 8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 2'b10, 2'd1, 2'b00, 4'b1100));
        tbl.push_back(idle);

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            check("vec", i, act(), exp_of(tbl[i]));
        end

        // reset asserted between an accepted read and its return
        @(negedge clk);
        apply(mk(1'b0, 3'b100, 8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 2'b00, 2'd0, 2'b00, 4'b0000));
        #1;
        check("rstrd_idle", 0, act(), 19'd0);
        @(negedge clk);
        #1;
        check("rstrd_acc", 0, act(), {2'b10, 2'd1, 2'b10, 8'h11, 1'b0, 4'b0000});
        #2;
        rst = 1'b1;
        #1;
        check("rstrd_clear", 0, act(), 19'd0);
        @(negedge clk);
        rst = 1'b0;
        s_req = 1'b0;
        #1;
        check("rstrd_norv", 0, act(), 19'd0);

        // randomized traffic against the reference model
        @(negedge clk);
        apply(idle);
        rst = 1'b1;
        mem_clr = 1'b1;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 1'b0;
        model_reset();
        for (int n = 0; n < 2000; n++) random_cycle(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_mem_arbiter.md
# maze_mem_arbiter

Shares the single-port maze memory between the maze-solving controller (solver port) and a host port that loads or inspects the maze. Arbitration is round-robin with a lock for atomic multi-access sequences, such as check-then-mark of a cell. A hold limit prevents either side from starving the other. It sits between the solver/host and the maze memory and owns every memory strobe.

## Interface
- ADDR_W, 8, cell address width (16x16 maze, 1-bit cells)
- MAX_HOLD, 16, accepted accesses allowed per grant before forced release when the other port waits (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- s_req  in  1  solver requests memory
- s_lock  in  1  solver keeps grant after req drops
- s_wr  in  1  1 = write, 0 = read
- s_addr  in  ADDR_W  cell address
- s_wdata  in  1  write data
- s_gnt  out  1  solver owns memory (registered)
- s_rvalid  out  1  read data valid (registered)
- s_rdata  out  1  read data
- h_req, h_lock, h_wr, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata: host port, identical semantics
- m_loc  out  ADDR_W  memory address
- m_dIn  out  1  memory write data
- m_rd  out  1  memory read strobe
- m_wr  out  1  memory write strobe
- m_dOut  in  1  memory read data, valid the cycle after m_rd
- owner  out  2  0 none, 1 solver, 2 host

## Operation
- FSM states: IDLE, GNT_S, GNT_H. Reset → IDLE, last_owner = HOST, so the solver wins the first tie. Hold counter = 0.
- IDLE, single requester: go to its grant state. Both requesting: grant the port that is not last_owner.
- Accepted access: the cycle where gnt=1 and req=1.
  - m_rd = ~wr, m_wr = wr, m_loc/m_dIn taken from the owner, all combinational from the registered grant.
  - When nobody holds an accepted access, all m_* outputs = 0.
- Hold counter increments per accepted access and clears on every grant change.
- Release from GNT_x, when any of the following holds:
  - req=0 and lock=0, or
  - the counter reaches MAX_HOLD while the other port requests. Lock is ignored in this case.
- On release: last_owner ← x. If the other port requests, go directly to its grant, with no IDLE bubble. Otherwise go to IDLE.
- Lock with req=0 keeps the grant with no accesses, and the counter does not advance.
- Read return: an rvalid/rdata pair goes to the port that issued the read, even if the grant has moved since.
- Write to the address read in the same cycle is impossible: there is one access per cycle.

## Timing
- Reset values: s_gnt=h_gnt=0, s_rvalid=h_rvalid=0, s_rdata=h_rdata=0, owner=0, m_rd=m_wr=0, m_loc=0, m_dIn=0.
- Assertion of rst at any cycle clears all of the above immediately. In-flight rvalid is dropped.
- req rises at cycle n from IDLE → gnt=1 at n+1. The first access is possible at n+1.
- Read accepted at k → rvalid=1 for exactly one cycle at k+1, with rdata = m_dOut.
- Write accepted at k → memory updated at the k clock edge.
- Release condition at k → old gnt=0 at k+1. The other gnt=1 at k+1 if it is requesting.
- Back-to-back accesses: one per cycle while req stays high.
- gnt is never high on both ports. owner always matches the gnt bits.

## Structure
- maze_pkg: ADDR_W constant, owner encoding (OWN_NONE/OWN_SLV/OWN_HST), FSM state type.
- Sub-module rr_pick2: combinational two-way round-robin choice from (s_req, h_req, last_owner).
- Hold counter and read-return tag registers stay inline.

## Test plan
- Reset mid-read: read accepted, rst asserted before k+1 → no rvalid, all outputs 0, owner=0.
- Solver alone: s_req at cycle 2, read addr 0x11 holding 1 → s_gnt at 3, m_rd at 3, s_rvalid=1 and s_rdata=1 at 4.
- Tie after reset: both req at cycle 1 → s_gnt at 2. Solver drops req at 5 → h_gnt=1 at 6 with no idle cycle.
- Lock: solver reads 0x23, drops req with lock=1 for 3 cycles, then writes 0x23=1 while host requests throughout → host not granted until solver lock=0 and req=0.
- Starvation: MAX_HOLD=4, solver streams with lock=1, host waiting → 4 solver accesses, then h_gnt=1 on the next cycle.
- Cross-grant read return: host reads 0xFF and releases in the same cycle, solver granted → h_rvalid at k+1, s_rvalid stays 0.
